key_event_decoder: RTL

- Consumes the debounced key level produced by the key debouncer and classifies it into one-cycle event pulses: press, release, short press, long press, hold-repeat and double click.
- Sits between the debouncer and the control logic (counters, mode selectors) that react to user keys.
- The key is active-low: 0 means pressed, 1 means released.

---
 rtl/key_event_if.sv | 25 ++
 rtl/key_event_decoder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/key_event_if.sv
// Key level in, classified one-cycle key events out.
interface key_event_if;
  logic key_db;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic hold_repeat;
  logic double_click;
  logic busy;

  // Producer of the key level; consumer of the events.
  modport master (
    output key_db,
    input  press_pulse, release_pulse, short_press, long_press,
           hold_repeat, double_click, busy
  );

  // The decoder itself.
  modport slave (
    input  key_db,
    output press_pulse, release_pulse, short_press, long_press,
           hold_repeat, double_click, busy
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies a debounced active-low key level into press/release,
// short/long press, hold-repeat and double-click pulses.
module key_event_decoder #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned DCLICK_CYCLES = 300,
  parameter int unsigned REPEAT_CYCLES = 100
) (
  input logic       clk,
  input logic       rst_n,
  key_event_if.slave kif
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q;
  logic             fall, rise;
  logic             cnt_reload;
  logic             short_d, long_d, repeat_d, dclick_d;

  logic press_q, release_q, short_q, long_q, repeat_q, dclick_q, busy_q;

  // Edges of the key level (key is active-low: fall = press).
  assign fall = key_q & ~kif.key_db;
  assign rise = ~key_q & kif.key_db;

  // Next-state, counter and classification decode; rise/fall beat timeouts.
  always_comb begin
    state_d    = state_q;
    cnt_reload = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    dclick_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) state_d = PRESS1;
      end
      PRESS1: begin
        if (rise) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end
      end
      WAIT2: begin
        if (fall) begin
          state_d = PRESS2;
        end else if (cnt_q == DCLICK_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (rise) begin
          dclick_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rise) begin
          state_d = IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d   = 1'b1;
          cnt_reload = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d != state_q) || cnt_reload) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter, edge history and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      dclick_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= kif.key_db;
      press_q   <= fall;
      release_q <= rise;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      dclick_q  <= dclick_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = release_q;
  assign kif.short_press   = short_q;
  assign kif.long_press    = long_q;
  assign kif.hold_repeat   = repeat_q;
  assign kif.double_click  = dclick_q;
  assign kif.busy          = busy_q;

endmodule
